// File: rtl/sequence_insert_controller.sv
// sequence_insert_controller
// Replaces SEQ_LINES consecutive active lines after each vertical blanking
// with words from the sequence generator, drives the generator load/enable
// strobes and stretches V_out over the inserted lines plus a guard interval
// so the downstream rotator leaves them unscrambled.
module sequence_insert_controller #(
    parameter int DATA_W       = 10,
    parameter int ACTIVE_WORDS = 1440,
    parameter int SEQ_LINES    = 1,
    parameter int GUARD        = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              H,
    input  logic              V,
    input  logic              insert_en,
    input  logic [DATA_W-1:0] bt656_stream_in,
    input  logic [DATA_W-1:0] sequence_in,
    output logic [DATA_W-1:0] bt656_stream_out,
    output logic              V_out,
    output logic              enable_generator,
    output logic              load_generator,
    output logic              busy,
    output logic [3:0]        lines_done
);

    localparam int PIX_W = $clog2(ACTIVE_WORDS + 1);
    localparam int G_W   = (GUARD > 1) ? $clog2(GUARD) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(ACTIVE_WORDS);
    localparam logic [G_W-1:0]   G_LAST   = G_W'(GUARD - 1);
    localparam logic [3:0]       SEQ_LAST = 4'(SEQ_LINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VBLANK,
        S_ARM,
        S_WAIT_LINE,
        S_INSERT,
        S_GUARD
    } state_t;

    state_t           state_q, state_d;
    logic             prev_h_q, prev_v_q;
    logic             v_ext_q, v_ext_d;
    logic             frame_en_q, frame_en_d;
    logic             allow_out_q, allow_out_d;
    logic             enable_q, enable_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic [3:0]       lines_done_q, lines_done_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [G_W-1:0]   g_q, g_d;

    logic h_fall, h_rise, v_fall;

    assign h_fall = prev_h_q & ~H;
    assign h_rise = ~prev_h_q & H;
    assign v_fall = prev_v_q & ~V;

    // Next-state and registered-output decode; a truncated frame overrides everything.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        v_ext_d      = v_ext_q;
        frame_en_d   = frame_en_q;
        allow_out_d  = allow_out_q;
        enable_d     = enable_q;
        load_d       = load_q;
        busy_d       = busy_q;
        lines_done_d = lines_done_q;
        pix_d        = pix_q;
        g_d          = g_q;

        case (state_q)
            S_IDLE: begin
                if (V) begin
                    state_d      = S_VBLANK;
                    // V itself already covers the blanking; only extend when this frame inserts,
                    // so a bypass frame gets V_out identical to V with no trailing cycle.
                    v_ext_d      = insert_en;
                    frame_en_d   = insert_en;
                    lines_done_d = '0;
                end
            end
            S_VBLANK: begin
                if (v_fall) begin
                    if (frame_en_q) begin
                        state_d  = S_ARM;
                        load_d   = 1'b1;
                        enable_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        v_ext_d = 1'b0;
                    end
                end
            end
            S_ARM, S_WAIT_LINE: begin
                if (h_fall) begin
                    state_d     = S_INSERT;
                    load_d      = 1'b0;
                    enable_d    = 1'b1;
                    allow_out_d = 1'b1;
                    pix_d       = PIX_W'(1);
                end
            end
            S_INSERT: begin
                pix_d = (pix_q == PIX_LAST) ? pix_q : pix_q + PIX_W'(1);
                // A line ends on the last word or on an early H rise (short line).
                if ((pix_q == PIX_LAST) || h_rise) begin
                    state_d      = S_GUARD;
                    allow_out_d  = 1'b0;
                    enable_d     = 1'b0;
                    lines_done_d = lines_done_q + 4'd1;
                    g_d          = '0;
                end
            end
            S_GUARD: begin
                if (g_q == G_LAST) begin
                    if (lines_done_q < SEQ_LAST) begin
                        state_d  = S_WAIT_LINE;
                        enable_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        v_ext_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    g_d = g_q + G_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // V returning mid-frame abandons the frame and treats this as a new blanking.
        if (V && (state_q != S_IDLE) && (state_q != S_VBLANK)) begin
            state_d      = S_VBLANK;
            allow_out_d  = 1'b0;
            enable_d     = 1'b0;
            load_d       = 1'b0;
            busy_d       = 1'b0;
            v_ext_d      = insert_en;
            frame_en_d   = insert_en;
            lines_done_d = '0;
        end
    end

    // State and edge-detect registers; edge history tracks the live inputs during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            prev_h_q     <= H;
            prev_v_q     <= V;
            v_ext_q      <= 1'b0;
            frame_en_q   <= 1'b0;
            allow_out_q  <= 1'b0;
            enable_q     <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            lines_done_q <= '0;
            pix_q        <= '0;
            g_q          <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q      <= state_d;
            prev_h_q     <= H;
            prev_v_q     <= V;
            v_ext_q      <= v_ext_d;
            frame_en_q   <= frame_en_d;
            allow_out_q  <= allow_out_d;
            enable_q     <= enable_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            lines_done_q <= lines_done_d;
            pix_q        <= pix_d;
            g_q          <= g_d;
        end
    end

    // reset_n in the select forces passthrough the instant reset asserts.
    assign bt656_stream_out = (allow_out_q && reset_n) ? sequence_in : bt656_stream_in;
    assign V_out            = V | v_ext_q;
    assign enable_generator = enable_q;
    assign load_generator   = load_q;
    assign busy             = busy_q;
    assign lines_done       = lines_done_q;

endmodule

// File: tb/tb_sequence_insert_controller.sv
// Testbench for sequence_insert_controller: three instances (SEQ_LINES 1,2,3)
// share one stimulus; ACTIVE_WORDS = 8, GUARD = 4. Inputs change 1 ns after
// the rising edge, outputs are sampled on the falling edge.
module tb_sequence_insert_controller;

    localparam int DW = 10;
    localparam int AW = 8;
    localparam int GD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          H = 1'b1;
    logic          V = 1'b0;
    logic          insert_en = 1'b0;
    logic [DW-1:0] stream_in = '0;
    logic [DW-1:0] seq_in = '1;

    logic [DW-1:0] out_w    [3];
    logic          v_out_w  [3];
    logic          en_w     [3];
    logic          load_w   [3];
    logic          busy_w   [3];
    logic [3:0]    lines_w  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        sequence_insert_controller #(
            .DATA_W(DW), .ACTIVE_WORDS(AW), .SEQ_LINES(gi + 1), .GUARD(GD)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .H(H), .V(V), .insert_en(insert_en),
            .bt656_stream_in(stream_in), .sequence_in(seq_in),
            .bt656_stream_out(out_w[gi]), .V_out(v_out_w[gi]),
            .enable_generator(en_w[gi]), .load_generator(load_w[gi]),
            .busy(busy_w[gi]), .lines_done(lines_w[gi])
        );
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int load_rises = 0;
    int bypass_bad = 0;
    logic prev_ld = 1'b0;

    typedef struct {
        logic       h, v, ie;
        logic       sub, vout, load, en, busy;
        logic [3:0] lines;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic [2:0] in_b, input logic [4:0] ex_b, input logic [3:0] ln);
        vec_t r;
        {r.h, r.v, r.ie} = in_b;
        {r.sub, r.vout, r.load, r.en, r.busy} = ex_b;
        r.lines = ln;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns at the falling edge with outputs settled.
    task automatic cyc(input logic h, input logic v, input logic ie);
        @(posedge clk);
        #1;
        H = h;
        V = v;
        insert_en = ie;
        stream_in = DW'($urandom);
        seq_in = ~stream_in;
        @(negedge clk);
    endtask

    // n cycles of constant H/V/insert_en, tallying behaviour of instance d.
    task automatic seg(input logic h, input logic v, input logic ie, input int n, input int d,
                       output int n_sub, output int n_en, output int n_vout);
        n_sub = 0;
        n_en = 0;
        n_vout = 0;
        for (int i = 0; i < n; i++) begin
            cyc(h, v, ie);
            if (out_w[d] === seq_in) n_sub++;
            if (en_w[d]) n_en++;
            if (v_out_w[d]) n_vout++;
            if (load_w[d] && !prev_ld) load_rises++;
            prev_ld = load_w[d];
            for (int j = 0; j < 3; j++)
                if (out_w[j] !== stream_in || load_w[j] || en_w[j] || v_out_w[j] !== V) bypass_bad++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        H = 1'b1;
        V = 1'b0;
        insert_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        prev_ld = 1'b0;
        load_rises = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, e, vo;

        // One SEQ_LINES=1 frame, cycle by cycle: {H,V,ie} / {sub,vout,load,en,busy} / lines.
        tbl[0]  = mk(3'b101, 5'b00000, 4'd0);
        tbl[1]  = mk(3'b111, 5'b01000, 4'd0);
        tbl[2]  = mk(3'b111, 5'b01000, 4'd0);
        tbl[3]  = mk(3'b100, 5'b01000, 4'd0);   // V falls, insert_en already latched
        tbl[4]  = mk(3'b100, 5'b01111, 4'd0);   // ARM: load + enable
        tbl[5]  = mk(3'b000, 5'b01111, 4'd0);   // H falls
        for (int i = 6; i < 14; i++)
            tbl[i] = mk(3'b000, 5'b11011, 4'd0); // 8 substituted words
        for (int i = 14; i < 18; i++)
            tbl[i] = mk(3'b100, 5'b01001, 4'd1); // guard
        tbl[18] = mk(3'b100, 5'b00000, 4'd1);
        tbl[19] = mk(3'b000, 5'b00000, 4'd1);   // H fall in IDLE does nothing

        // Reset state.
        reset_n = 1'b0;
        #3;
        chk("reset.out", 32'(out_w[0]), 32'(stream_in));
        chk("reset.vout", 32'(v_out_w[0]), 32'(V));
        chk("reset.busy", 32'(busy_w[0]), 32'd0);
        chk("reset.lines", 32'(lines_w[0]), 32'd0);
        do_reset();

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].h, tbl[i].v, tbl[i].ie);
            chk($sformatf("vec%0d.out", i), 32'(out_w[0]), 32'(tbl[i].sub ? seq_in : stream_in));
            chk($sformatf("vec%0d.vout", i), 32'(v_out_w[0]), 32'(tbl[i].vout));
            chk($sformatf("vec%0d.load", i), 32'(load_w[0]), 32'(tbl[i].load));
            chk($sformatf("vec%0d.en", i), 32'(en_w[0]), 32'(tbl[i].en));
            chk($sformatf("vec%0d.busy", i), 32'(busy_w[0]), 32'(tbl[i].busy));
            chk($sformatf("vec%0d.lines", i), 32'(lines_w[0]), 32'(tbl[i].lines));
        end

        // Three lines with SEQ_LINES=3 (instance 2), H blank equal to the guard.
        do_reset();
        seg(1'b1, 1'b1, 1'b1, 2, 2, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, 2, 2, s, e, vo);
        for (int ln = 1; ln <= 3; ln++) begin
            seg(1'b0, 1'b0, 1'b1, AW + 1, 2, s, e, vo);
            chk($sformatf("s3.line%0d.sub", ln), 32'(s), 32'(AW));
            chk($sformatf("s3.line%0d.en", ln), 32'(e), 32'(AW + 1));
            seg(1'b1, 1'b0, 1'b1, GD, 2, s, e, vo);
            chk($sformatf("s3.blank%0d.sub", ln), 32'(s), 32'd0);
            chk($sformatf("s3.blank%0d.en", ln), 32'(e), 32'd0);
            chk($sformatf("s3.blank%0d.vout", ln), 32'(vo), 32'(GD));
            chk($sformatf("s3.blank%0d.lines", ln), 32'(lines_w[2]), 32'(ln));
        end
        cyc(1'b1, 1'b0, 1'b1);
        chk("s3.end.vout", 32'(v_out_w[2]), 32'd0);
        chk("s3.end.busy", 32'(busy_w[2]), 32'd0);
        chk("s3.end.lines", 32'(lines_w[2]), 32'd3);
        chk("s3.load_pulses", 32'(load_rises), 32'd1);

        // Bypass frame: insert_en low at the V rise, every instance passes through.
        do_reset();
        bypass_bad = 0;
        seg(1'b1, 1'b1, 1'b0, 2, 0, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, 2, 0, s, e, vo);
        for (int ln = 0; ln < 2; ln++) begin
            seg(1'b0, 1'b0, 1'b1, AW + 1, 0, s, e, vo);
            seg(1'b1, 1'b0, 1'b1, GD, 0, s, e, vo);
        end
        chk("bypass.cycles_differing", 32'(bypass_bad), 32'd0);
        chk("bypass.lines", 32'(lines_w[2]), 32'd0);

        // V returns during the second line of SEQ_LINES=2 (instance 1).
        do_reset();
        seg(1'b1, 1'b1, 1'b1, 2, 1, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, 2, 1, s, e, vo);
        seg(1'b0, 1'b0, 1'b1, AW + 1, 1, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, GD, 1, s, e, vo);
        chk("abort.first_line_lines", 32'(lines_w[1]), 32'd1);
        seg(1'b0, 1'b0, 1'b1, 3, 1, s, e, vo);
        chk("abort.partial_sub", 32'(s), 32'd2);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("abort.out", 32'(out_w[1]), 32'(stream_in));
        chk("abort.en", 32'(en_w[1]), 32'd0);
        chk("abort.load", 32'(load_w[1]), 32'd0);
        chk("abort.lines", 32'(lines_w[1]), 32'd0);
        chk("abort.vout", 32'(v_out_w[1]), 32'd1);
        seg(1'b1, 1'b1, 1'b1, 1, 1, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, 2, 1, s, e, vo);
        seg(1'b0, 1'b0, 1'b1, AW + 1, 1, s, e, vo);
        chk("abort.next_sub", 32'(s), 32'(AW));
        seg(1'b1, 1'b0, 1'b1, GD, 1, s, e, vo);
        chk("abort.next_lines", 32'(lines_w[1]), 32'd1);
        seg(1'b0, 1'b0, 1'b1, AW + 1, 1, s, e, vo);
        chk("abort.next2_sub", 32'(s), 32'(AW));
        seg(1'b1, 1'b0, 1'b1, GD, 1, s, e, vo);
        chk("abort.next2_vout", 32'(vo), 32'(GD));
        cyc(1'b1, 1'b0, 1'b1);
        chk("abort.done_lines", 32'(lines_w[1]), 32'd2);
        chk("abort.done_vout", 32'(v_out_w[1]), 32'd0);

        // Short line: H rises while pix = 5 (instance 0).
        do_reset();
        seg(1'b1, 1'b1, 1'b1, 2, 0, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, 2, 0, s, e, vo);
        seg(1'b0, 1'b0, 1'b1, 5, 0, s, e, vo);
        chk("short.sub_low", 32'(s), 32'd4);
        seg(1'b1, 1'b0, 1'b1, 1, 0, s, e, vo);
        chk("short.sub_hrise", 32'(s), 32'd1);
        seg(1'b1, 1'b0, 1'b1, GD, 0, s, e, vo);
        chk("short.guard_sub", 32'(s), 32'd0);
        chk("short.guard_en", 32'(e), 32'd0);
        chk("short.guard_vout", 32'(vo), 32'(GD));
        cyc(1'b1, 1'b0, 1'b1);
        chk("short.lines", 32'(lines_w[0]), 32'd1);
        chk("short.vout", 32'(v_out_w[0]), 32'd0);
        chk("short.busy", 32'(busy_w[0]), 32'd0);

        // reset_n pulsed low in the middle of an inserted line.
        do_reset();
        seg(1'b1, 1'b1, 1'b1, 2, 0, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, 2, 0, s, e, vo);
        seg(1'b0, 1'b0, 1'b1, 4, 0, s, e, vo);
        chk("rst.pre_sub", 32'(out_w[0]), 32'(seq_in));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst.out", 32'(out_w[0]), 32'(stream_in));
        chk("rst.vout", 32'(v_out_w[0]), 32'(V));
        chk("rst.en", 32'(en_w[0]), 32'd0);
        chk("rst.load", 32'(load_w[0]), 32'd0);
        chk("rst.busy", 32'(busy_w[0]), 32'd0);
        chk("rst.lines", 32'(lines_w[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bypass_bad = 0;
        seg(1'b0, 1'b0, 1'b1, 5, 0, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, GD, 0, s, e, vo);
        seg(1'b0, 1'b0, 1'b1, AW + 1, 0, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, GD, 0, s, e, vo);
        chk("rst.no_insert_until_v", 32'(bypass_bad), 32'd0);
        seg(1'b1, 1'b1, 1'b1, 2, 0, s, e, vo);
        seg(1'b1, 1'b0, 1'b1, 2, 0, s, e, vo);
        seg(1'b0, 1'b0, 1'b1, AW + 1, 0, s, e, vo);
        chk("rst.resume_sub", 32'(s), 32'(AW));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
